// File: rtl/tb_irq_err_sched.sv
// Clocked IRQ and ITCM bus-error injection scheduler for the simulation top, armed by a commit PC.
// Registered outputs, bus_err_o gated combinationally; no flow control, gaps from free-running LFSRs.
module tb_irq_err_sched #(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] PC_START   = 32'h8000015C,
    parameter logic [PC_W-1:0] PC_ACK_EXT = 32'h800000A6,
    parameter logic [PC_W-1:0] PC_ACK_SFT = 32'h800000BE,
    parameter logic [PC_W-1:0] PC_ACK_TMR = 32'h800000D6,
    parameter int unsigned     STOP_CNT   = 32,
    parameter int unsigned     DLY_W      = 10,
    parameter int unsigned     ELO_W      = 4,
    parameter int unsigned     EHI_W      = 8,
    parameter logic [15:0]     SEED_EXT   = 16'hACE1,
    parameter logic [15:0]     SEED_SFT   = 16'h1D2B,
    parameter logic [15:0]     SEED_TMR   = 16'h7F31,
    parameter logic [15:0]     SEED_ERR   = 16'h5A5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cmt_valid,
    input  logic [PC_W-1:0]  cmt_pc,
    input  logic [31:0]      tohost_cnt,
    input  logic             status_mie,
    input  logic             itcm_rsp_read,
    input  logic [DLY_W-1:0] dly_fix,
    output logic             ext_irq_o,
    output logic             sft_irq_o,
    output logic             tmr_irq_o,
    output logic             bus_err_o,
    output logic             armed_o,
    output logic [15:0]      inj_cnt_o
);

    localparam logic [15:0] POLY = 16'hB400;
    localparam int CW = DLY_W + 1;
    localparam int EW = ((ELO_W > EHI_W) ? ELO_W : EHI_W) + 1;
    localparam logic [3:0][15:0]      SEEDS  = {SEED_ERR, SEED_TMR, SEED_SFT, SEED_EXT};
    localparam logic [2:0][PC_W-1:0] ACK_PC = {PC_ACK_TMR, PC_ACK_SFT, PC_ACK_EXT};

    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_ASSERT, I_DONE} irq_st_t;
    typedef enum logic [1:0] {E_IDLE, E_LO, E_HI, E_DONE} err_st_t;

    logic [3:0][15:0] lfsr;
    logic             armed_r;
    logic             stop;
    logic [2:0]       irq_q;
    logic [2:0]       rise;
    logic [15:0]      inj_r;
    logic [16:0]      inj_sum;

    assign stop = (tohost_cnt > 32'(STOP_CNT));

    // Index 0..2 feed the ext/sft/tmr channels, index 3 the bus-error channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEEDS;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lfsr[i] <= {1'b0, lfsr[i][15:1]} ^ (lfsr[i][0] ? POLY : 16'h0000);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
        end else if (cmt_valid && (cmt_pc == PC_START)) begin
            armed_r <= 1'b1;
        end
    end

    genvar g;
    for (g = 0; g < 3; g++) begin : g_irq
        irq_st_t       st, st_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic [CW-1:0] gap;
        logic          ack;
        logic          irq_r;

        assign gap = (dly_fix != '0) ? {1'b0, dly_fix}
                                     : ({1'b0, lfsr[g][DLY_W-1:0]} + CW'(1));
        assign ack = cmt_valid && (cmt_pc == ACK_PC[g]);

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            if (!en) begin
                // DONE survives an enable drop so a stopped channel never restarts.
                if (st != I_DONE) st_nxt = I_IDLE;
            end else begin
                case (st)
                    I_IDLE: begin
                        if (armed_r) begin
                            st_nxt  = I_WAIT;
                            cnt_nxt = gap;
                        end
                    end
                    I_WAIT: begin
                        cnt_nxt = cnt - CW'(1);
                        if (cnt == CW'(1)) st_nxt = I_ASSERT;
                    end
                    I_ASSERT: begin
                        if (ack) begin
                            if (stop) begin
                                st_nxt = I_DONE;
                            end else begin
                                st_nxt  = I_WAIT;
                                cnt_nxt = gap;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st    <= I_IDLE;
                cnt   <= '0;
                irq_r <= 1'b0;
            end else begin
                st    <= st_nxt;
                cnt   <= cnt_nxt;
                irq_r <= (st_nxt == I_ASSERT);
            end
        end

        assign irq_q[g] = irq_r;
        assign rise[g]  = (st == I_WAIT) && (st_nxt == I_ASSERT);
    end

    err_st_t       e_st, e_nxt;
    logic [EW-1:0] e_cnt, e_cnt_nxt;
    logic [EW-1:0] lo_len, hi_len;
    logic          err_raw;

    assign lo_len = EW'(lfsr[3][ELO_W-1:0]) + EW'(1);
    assign hi_len = EW'(lfsr[3][EHI_W-1:0]) + EW'(1);

    always_comb begin
        e_nxt     = e_st;
        e_cnt_nxt = e_cnt;
        if (!en) begin
            if (e_st != E_DONE) e_nxt = E_IDLE;
        end else begin
            case (e_st)
                E_IDLE: begin
                    if (armed_r) begin
                        e_nxt     = E_LO;
                        e_cnt_nxt = lo_len;
                    end
                end
                E_LO: begin
                    e_cnt_nxt = e_cnt - EW'(1);
                    if (e_cnt == EW'(1)) begin
                        e_nxt     = E_HI;
                        e_cnt_nxt = hi_len;
                    end
                end
                E_HI: begin
                    e_cnt_nxt = e_cnt - EW'(1);
                    if (e_cnt == EW'(1)) begin
                        if (stop) begin
                            e_nxt = E_DONE;
                        end else begin
                            e_nxt     = E_LO;
                            e_cnt_nxt = lo_len;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_st    <= E_IDLE;
            e_cnt   <= '0;
            err_raw <= 1'b0;
        end else begin
            e_st    <= e_nxt;
            e_cnt   <= e_cnt_nxt;
            err_raw <= (e_nxt == E_HI);
        end
    end

    // Up to three channels can fire together, so sum before saturating.
    assign inj_sum = {1'b0, inj_r} + 17'(rise[0]) + 17'(rise[1]) + 17'(rise[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_r <= '0;
        end else begin
            inj_r <= inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
        end
    end

    assign ext_irq_o = irq_q[0];
    assign sft_irq_o = irq_q[1];
    assign tmr_irq_o = irq_q[2];
    assign bus_err_o = err_raw & status_mie & itcm_rsp_read;
    assign armed_o   = armed_r;
    assign inj_cnt_o = inj_r;

endmodule

// File: tb/tb_tb_irq_err_sched.sv
// Scoreboard bench for tb_irq_err_sched: a deadline-based reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_tb_irq_err_sched;

    localparam logic [31:0] PC_START   = 32'h8000015C;
    localparam logic [31:0] PC_ACK_EXT = 32'h800000A6;
    localparam logic [31:0] PC_ACK_SFT = 32'h800000BE;
    localparam logic [31:0] PC_ACK_TMR = 32'h800000D6;
    localparam int K_IDLE = 0, K_PEND = 1, K_ON = 2, K_DONE = 3;
    localparam int B_IDLE = 0, B_LO = 1, B_HI = 2, B_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n, en, cmt_valid, status_mie, itcm_rsp_read;
    logic [31:0] cmt_pc, tohost_cnt;
    logic [9:0]  dly_fix;
    logic        ext_irq_o, sft_irq_o, tmr_irq_o, bus_err_o, armed_o;
    logic [15:0] inj_cnt_o;

    tb_irq_err_sched dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .tohost_cnt(tohost_cnt), .status_mie(status_mie), .itcm_rsp_read(itcm_rsp_read),
        .dly_fix(dly_fix), .ext_irq_o(ext_irq_o), .sft_irq_o(sft_irq_o), .tmr_irq_o(tmr_irq_o),
        .bus_err_o(bus_err_o), .armed_o(armed_o), .inj_cnt_o(inj_cnt_o)
    );

    always #10 clk = ~clk;

    typedef struct { int c; logic [20:0] v; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: channel mode plus the absolute cycle of its next event.
    bit          m_armed;
    int          m_ik[3];
    int          m_due[3];
    int          m_ek;
    int          m_eend;
    int          m_inj;
    logic [15:0] m_lfsr[4];

    function automatic logic [15:0] lfsr_next(logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [31:0] ack_pc(int c);
        case (c)
            0:       return PC_ACK_EXT;
            1:       return PC_ACK_SFT;
            default: return PC_ACK_TMR;
        endcase
    endfunction

    function automatic int gap(int c);
        if (dly_fix != 0) return int'(dly_fix);
        return int'(m_lfsr[c]) % 1024 + 1;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_ek = B_IDLE; m_eend = 0; m_inj = 0;
        for (int c = 0; c < 3; c++) begin m_ik[c] = K_IDLE; m_due[c] = 0; end
        m_lfsr[0] = 16'hACE1; m_lfsr[1] = 16'h1D2B; m_lfsr[2] = 16'h7F31; m_lfsr[3] = 16'h5A5A;
    endtask

    task automatic model_step();
        bit stop;
        int inc;
        stop = (tohost_cnt > 32);
        inc  = 0;
        for (int c = 0; c < 3; c++) begin
            if (m_ik[c] != K_DONE && !en) m_ik[c] = K_IDLE;
            else if (m_ik[c] == K_IDLE && m_armed) begin
                m_due[c] = cyc + 1 + gap(c); m_ik[c] = K_PEND;
            end else if (m_ik[c] == K_PEND && m_due[c] == cyc + 1) begin
                m_ik[c] = K_ON; inc++;
            end else if (m_ik[c] == K_ON && cmt_valid && cmt_pc == ack_pc(c)) begin
                if (stop) m_ik[c] = K_DONE;
                else begin m_due[c] = cyc + 1 + gap(c); m_ik[c] = K_PEND; end
            end
        end
        if (m_ek != B_DONE && !en) m_ek = B_IDLE;
        else if (m_ek == B_IDLE && m_armed) begin
            m_ek = B_LO; m_eend = cyc + int'(m_lfsr[3]) % 16 + 1;
        end else if (m_ek == B_LO && cyc == m_eend) begin
            m_ek = B_HI; m_eend = cyc + int'(m_lfsr[3]) % 256 + 1;
        end else if (m_ek == B_HI && cyc == m_eend) begin
            if (stop) m_ek = B_DONE;
            else begin m_ek = B_LO; m_eend = cyc + int'(m_lfsr[3]) % 16 + 1; end
        end
        m_inj = (m_inj + inc > 65535) ? 65535 : m_inj + inc;
        if (cmt_valid && cmt_pc == PC_START) m_armed = 1;
        for (int i = 0; i < 4; i++) m_lfsr[i] = lfsr_next(m_lfsr[i]);
    endtask

    task automatic tick();
        exp_t e;
        if (!rst_n) model_reset();
        e.c = cyc;
        e.v = {m_ik[0] == K_ON, m_ik[1] == K_ON, m_ik[2] == K_ON,
               (m_ek == B_HI) && status_mie && itcm_rsp_read, m_armed, 16'(m_inj)};
        exp_q.push_back(e);
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    task automatic commit(logic [31:0] pc);
        cmt_valid = 1'b1; cmt_pc = pc;
        tick();
        cmt_valid = 1'b0; cmt_pc = 32'h0;
    endtask

    initial begin : monitor
        exp_t e;
        logic [20:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ext_irq_o, sft_irq_o, tmr_irq_o, bus_err_o, armed_o, inj_cnt_o};
                n_cmp++;
                if (act !== e.v) begin
                    n_bad++;
                    $display("FAIL outputs cyc=%0d got=%h want=%h", e.c, act, e.v);
                end
            end
        end
    end

    initial begin : stim
        int budget, run, hi_runs, max_hi, inj_snap, s;
        bit prev, cur, seen;
        rst_n = 1'b0; en = 1'b0; cmt_valid = 1'b0; cmt_pc = 32'h0; tohost_cnt = 32'h0;
        status_mie = 1'b1; itcm_rsp_read = 1'b1; dly_fix = 10'd0;
        @(posedge clk); #1;
        model_reset();

        // Reset, arm at cycle 10, first assert at 17.
        repeat (3) tick();
        chk("reset_state", 32'({ext_irq_o, sft_irq_o, tmr_irq_o, bus_err_o, armed_o}), 32'h0);
        chk("reset_inj", 32'(inj_cnt_o), 32'h0);
        rst_n = 1'b1; en = 1'b1; dly_fix = 10'd5;
        while (cyc < 10) tick();
        commit(PC_START);
        chk("arm_at_11", 32'(armed_o), 32'd1);
        while (cyc < 16) tick();
        chk("irq_pre_17", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd0);
        tick();
        chk("irq_at_17", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd7);
        chk("inj_at_17", 32'(inj_cnt_o), 32'd3);

        // Acknowledge ext at 30: low at 31, back at 36.
        while (cyc < 30) tick();
        commit(PC_ACK_EXT);
        chk("ack_ext_31", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd3);
        while (cyc < 35) tick();
        chk("ext_low_35", 32'(ext_irq_o), 32'd0);
        tick();
        chk("ext_rearm_36", 32'(ext_irq_o), 32'd1);

        // Enable drop while all asserted, then restart with a gap of 3.
        repeat (3) tick();
        en = 1'b0;
        tick();
        chk("en_drop", 32'({ext_irq_o, sft_irq_o, tmr_irq_o, bus_err_o}), 32'd0);
        repeat (3) tick();
        dly_fix = 10'd3; en = 1'b1;
        repeat (3) tick();
        chk("en_rise_p3", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd0);
        tick();
        chk("en_rise_p4", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd7);

        // Bus-error gating inside a HI phase.
        budget = 600;
        while (m_ek != B_HI && budget > 0) begin tick(); budget--; end
        chk("hi_reached", 32'(bus_err_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            status_mie = k[1]; itcm_rsp_read = k[0];
            #1;
            chk("err_gate", 32'(bus_err_o), 32'(status_mie & itcm_rsp_read));
        end

        // Phase lengths observed on the DUT output.
        status_mie = 1'b1; itcm_rsp_read = 1'b1;
        tick();
        prev = bus_err_o; run = 1; seen = 0; hi_runs = 0; max_hi = 0; budget = 30000;
        while (hi_runs < 150 && budget > 0) begin
            tick(); budget--;
            cur = bus_err_o;
            if (cur == prev) run++;
            else begin
                if (seen) begin
                    if (prev) begin
                        chk("hi_len_range", 32'(run >= 1 && run <= 256), 32'd1);
                        hi_runs++;
                        if (run > max_hi) max_hi = run;
                    end else begin
                        chk("lo_len_range", 32'(run >= 1 && run <= 16), 32'd1);
                    end
                end
                seen = 1; run = 1; prev = cur;
            end
        end
        chk("phase_budget", 32'(hi_runs >= 150), 32'd1);
        chk("hi_spread", 32'(max_hi > 16), 32'd1);

        // Stop: ack tmr with tohost past threshold; it must stay quiet.
        tohost_cnt = 32'd33;
        chk("tmr_on_pre_stop", 32'(tmr_irq_o), 32'd1);
        commit(PC_ACK_TMR);
        inj_snap = m_inj;
        chk("tmr_stopped", 32'(tmr_irq_o), 32'd0);
        repeat (5000) tick();
        chk("tmr_still_off", 32'(tmr_irq_o), 32'd0);
        chk("inj_frozen", 32'(inj_cnt_o), 32'(inj_snap));

        // Reset in the middle of an ext WAIT.
        tohost_cnt = 32'd0; dly_fix = 10'd20;
        commit(PC_ACK_EXT);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", 32'({ext_irq_o, sft_irq_o, tmr_irq_o, bus_err_o, armed_o}), 32'd0);
        chk("rst_async_inj", 32'(inj_cnt_o), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1; dly_fix = 10'd2;
        repeat (60) tick();
        chk("no_irq_unarmed", 32'({ext_irq_o, sft_irq_o, tmr_irq_o, armed_o}), 32'd0);
        s = cyc;
        commit(PC_START);
        chk("rearm", 32'(armed_o), 32'd1);
        while (cyc < s + 3) tick();
        chk("rearm_p3", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd0);
        tick();
        chk("rearm_p4", 32'({ext_irq_o, sft_irq_o, tmr_irq_o}), 32'd7);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 8000; i++) begin
            en        = ($urandom_range(63) != 0);
            cmt_valid = 1'($urandom_range(1));
            case ($urandom_range(7))
                0:       cmt_pc = PC_START;
                1:       cmt_pc = PC_ACK_EXT;
                2:       cmt_pc = PC_ACK_SFT;
                3:       cmt_pc = PC_ACK_TMR;
                default: cmt_pc = $urandom();
            endcase
            status_mie    = 1'($urandom_range(1));
            itcm_rsp_read = 1'($urandom_range(1));
            dly_fix       = ($urandom_range(3) == 0) ? 10'($urandom_range(15)) : 10'd0;
            tohost_cnt    = (i > 6000) ? 32'(30 + $urandom_range(5)) : 32'($urandom_range(32));
            tick();
        end

        en = 1'b0; cmt_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
